// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage
//   Registered RV32I decode stage between fetch and execute. A valid/ready
//   handshake sits on both sides. A two-entry store (main + skid) lets fetch
//   push one more instruction while execute stalls, so o_ready can be a flop.
//   Illegal encodings still flow as bundles with o_illegal=1 and every op NOOP.
//   A saturating counter records how many of them were accepted.
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_flush             drop every held entry and this cycle's input
//   i_valid/o_ready     fetch-side handshake; i_instruction, i_pc
//   o_valid/i_ready     execute-side handshake
//   o_pc .. o_illegal   decoded bundle, driven from the main register
//   o_illegal_count     number of illegal instructions accepted, saturating
module rv32_decode_stage #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int WORD_SIZE         = 32,
   parameter bit ENABLE_JUMP       = 1'b1,
   parameter int ILLEGAL_CNT_WIDTH = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_flush,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [INSTRUCTION_WIDTH-1:0] i_instruction,
   input  logic [WORD_SIZE-1:0]         i_pc,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic [WORD_SIZE-1:0]         o_pc,
   output logic [3:0]                   o_alu_op,
   output logic [2:0]                   o_branch_op,
   output logic [1:0]                   o_jump,
   output logic                         o_pc_operand,
   output logic [WORD_SIZE-1:0]         o_imm,
   output logic [4:0]                   o_rs1,
   output logic [4:0]                   o_rs2,
   output logic [4:0]                   o_rd,
   output logic [1:0]                   o_mem_op,
   output logic [1:0]                   o_mem_size,
   output logic                         o_mem_sign_extend,
   output logic                         o_wb_en,
   output logic                         o_illegal,
   output logic [ILLEGAL_CNT_WIDTH-1:0] o_illegal_count
);

   localparam logic [3:0] ALU_NOOP = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB  = 4'd2,
                          ALU_SLL  = 4'd3,  ALU_SLT  = 4'd4,  ALU_SLTU = 4'd5,
                          ALU_XOR  = 4'd6,  ALU_SRL  = 4'd7,  ALU_SRA  = 4'd8,
                          ALU_OR   = 4'd9,  ALU_AND  = 4'd10, ALU_LUI  = 4'd11,
                          ALU_ADD_MEM = 4'd12;
   localparam logic [2:0] BRANCH_NOOP = 3'd0, BRANCH_BEQ  = 3'd1, BRANCH_BNE  = 3'd2,
                          BRANCH_BLT  = 3'd3, BRANCH_BGE  = 3'd4, BRANCH_BLTU = 3'd5,
                          BRANCH_BGEU = 3'd6;
   localparam logic [1:0] MEM_NOOP = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2;
   localparam logic [1:0] JUMP_JAL = 2'b01, JUMP_JALR = 2'b10;

   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL  = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

   localparam logic [1:0] ST_EMPTY = 2'd0, ST_MAIN = 2'd1, ST_SKID = 2'd2;

   typedef struct packed {
      logic [WORD_SIZE-1:0] pc;
      logic [3:0]           alu_op;
      logic [2:0]           branch_op;
      logic [1:0]           jump;
      logic                 pc_operand;
      logic [WORD_SIZE-1:0] imm;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [4:0]           rd;
      logic [1:0]           mem_op;
      logic [1:0]           mem_size;
      logic                 mem_sign_extend;
      logic                 wb_en;
      logic                 illegal;
   } bundle_t;

   function automatic logic [WORD_SIZE-1:0] sext32(input logic [31:0] v);
      logic signed [WORD_SIZE-1:0] r;
      r = $signed(v);
      return r;
   endfunction

   function automatic bundle_t decode(input logic [31:0] instr, input logic [WORD_SIZE-1:0] pc);
      bundle_t     b;
      logic        bad;
      logic [6:0]  opcode;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
      opcode = instr[6:0];
      f3     = instr[14:12];
      f7     = instr[31:25];
      imm_i  = {{20{instr[31]}}, instr[31:20]};
      imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      imm_u  = {instr[31:12], 12'b0};
      imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      imm_sh = {27'b0, instr[24:20]};
      b      = '0;
      b.pc   = pc;
      bad    = (instr[1:0] != 2'b11);
      case (opcode)
         OP_LUI: begin
            b.alu_op = ALU_LUI; b.rd = instr[11:7]; b.imm = sext32(imm_u); b.wb_en = 1'b1;
         end
         OP_AUIPC: begin
            b.alu_op = ALU_ADD; b.pc_operand = 1'b1; b.rd = instr[11:7];
            b.imm = sext32(imm_u); b.wb_en = 1'b1;
         end
         OP_JAL: begin
            bad = bad | !ENABLE_JUMP;
            b.alu_op = ALU_ADD; b.jump = JUMP_JAL; b.pc_operand = 1'b1;
            b.rd = instr[11:7]; b.imm = sext32(imm_j); b.wb_en = 1'b1;
         end
         OP_JALR: begin
            bad = bad | !ENABLE_JUMP | (f3 != 3'b000);
            b.alu_op = ALU_ADD; b.jump = JUMP_JALR; b.rs1 = instr[19:15];
            b.rd = instr[11:7]; b.imm = sext32(imm_i); b.wb_en = 1'b1;
         end
         OP_BRANCH: begin
            b.rs1 = instr[19:15]; b.rs2 = instr[24:20]; b.imm = sext32(imm_b);
            case (f3)
               3'b000:  b.branch_op = BRANCH_BEQ;
               3'b001:  b.branch_op = BRANCH_BNE;
               3'b100:  b.branch_op = BRANCH_BLT;
               3'b101:  b.branch_op = BRANCH_BGE;
               3'b110:  b.branch_op = BRANCH_BLTU;
               3'b111:  b.branch_op = BRANCH_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OP_LOAD: begin
            bad = bad | (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
            b.alu_op = ALU_ADD_MEM; b.mem_op = MEM_LOAD; b.mem_size = f3[1:0];
            b.mem_sign_extend = !f3[2]; b.rs1 = instr[19:15]; b.rd = instr[11:7];
            b.imm = sext32(imm_i); b.wb_en = 1'b1;
         end
         OP_STORE: begin
            bad = bad | (f3 >= 3'b011);
            b.alu_op = ALU_ADD_MEM; b.mem_op = MEM_STORE; b.mem_size = f3[1:0];
            b.rs1 = instr[19:15]; b.rs2 = instr[24:20]; b.imm = sext32(imm_s);
         end
         OP_IMM: begin
            b.rs1 = instr[19:15]; b.rd = instr[11:7]; b.wb_en = 1'b1; b.imm = sext32(imm_i);
            case (f3)
               3'b000: b.alu_op = ALU_ADD;
               3'b010: b.alu_op = ALU_SLT;
               3'b011: b.alu_op = ALU_SLTU;
               3'b100: b.alu_op = ALU_XOR;
               3'b110: b.alu_op = ALU_OR;
               3'b111: b.alu_op = ALU_AND;
               3'b001: begin
                  b.alu_op = ALU_SLL; b.imm = sext32(imm_sh); bad = bad | (f7 != 7'b0000000);
               end
               default: begin
                  b.imm = sext32(imm_sh);
                  if (f7 == 7'b0000000)      b.alu_op = ALU_SRL;
                  else if (f7 == 7'b0100000) b.alu_op = ALU_SRA;
                  else                       bad = 1'b1;
               end
            endcase
         end
         OP_REG: begin
            b.rs1 = instr[19:15]; b.rs2 = instr[24:20]; b.rd = instr[11:7]; b.wb_en = 1'b1;
            case ({f7, f3})
               {7'b0000000, 3'b000}: b.alu_op = ALU_ADD;
               {7'b0100000, 3'b000}: b.alu_op = ALU_SUB;
               {7'b0000000, 3'b001}: b.alu_op = ALU_SLL;
               {7'b0000000, 3'b010}: b.alu_op = ALU_SLT;
               {7'b0000000, 3'b011}: b.alu_op = ALU_SLTU;
               {7'b0000000, 3'b100}: b.alu_op = ALU_XOR;
               {7'b0000000, 3'b101}: b.alu_op = ALU_SRL;
               {7'b0100000, 3'b101}: b.alu_op = ALU_SRA;
               {7'b0000000, 3'b110}: b.alu_op = ALU_OR;
               {7'b0000000, 3'b111}: b.alu_op = ALU_AND;
               default:              bad = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase
      // An illegal bundle keeps only its PC so execute can still trap on it.
      if (bad) begin
         b         = '0;
         b.pc      = pc;
         b.illegal = 1'b1;
      end
      return b;
   endfunction

   logic [1:0]                   state_q, state_d;
   bundle_t                      main_q, main_d, skid_q, skid_d, dec;
   logic [ILLEGAL_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                         accept, out_xfer;

   assign o_valid = (state_q != ST_EMPTY);
   assign o_ready = (state_q != ST_SKID);

   always_comb begin
      dec      = decode(i_instruction, i_pc);
      accept   = i_valid && o_ready && !i_flush;
      out_xfer = o_valid && i_ready;
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_EMPTY: if (accept) begin
            main_d  = dec;
            state_d = ST_MAIN;
         end
         ST_MAIN: begin
            if (accept && out_xfer) begin
               main_d = dec;
            end else if (accept) begin
               skid_d  = dec;
               state_d = ST_SKID;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_SKID: if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_MAIN;
         end
         default: state_d = ST_EMPTY;
      endcase
      if (i_flush) state_d = ST_EMPTY;
      if (accept && dec.illegal && (cnt_q != '1)) cnt_d = cnt_q + ILLEGAL_CNT_WIDTH'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_pc              = main_q.pc;
   assign o_alu_op          = main_q.alu_op;
   assign o_branch_op       = main_q.branch_op;
   assign o_jump            = main_q.jump;
   assign o_pc_operand      = main_q.pc_operand;
   assign o_imm             = main_q.imm;
   assign o_rs1             = main_q.rs1;
   assign o_rs2             = main_q.rs2;
   assign o_rd              = main_q.rd;
   assign o_mem_op          = main_q.mem_op;
   assign o_mem_size        = main_q.mem_size;
   assign o_mem_sign_extend = main_q.mem_sign_extend;
   assign o_wb_en           = main_q.wb_en;
   assign o_illegal         = main_q.illegal;
   assign o_illegal_count   = cnt_q;

endmodule
